// File: rtl/bpsk_modulator_if.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_modulator_if
// Description : Bit-in / sample-out stream bundle of the BPSK modulator.
//               The slave side is the modulator; the master side feeds data
//               bits and consumes modulated samples.
// Revision    : 1.0 - initial release
// ============================================================================
interface bpsk_modulator_if;
   logic              din_bit;
   logic              din_valid;
   logic              din_ready;
   logic signed [7:0] dout;
   logic              dout_valid;

   modport master (
      output din_bit,
      output din_valid,
      input  din_ready,
      input  dout,
      input  dout_valid
   );

   modport slave (
      input  din_bit,
      input  din_valid,
      output din_ready,
      output dout,
      output dout_valid
   );
endinterface
`default_nettype wire

// File: rtl/bpsk_modulator.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_modulator
// Description : BPSK transmitter. One data bit per symbol is accepted over a
//               valid/ready handshake, mapped to a 0 / pi carrier phase and
//               multiplied onto a phase-accumulator sine carrier. Output is
//               signed 8-bit samples, SYM_DIV samples per bit, 2-cycle latency.
//               Optional feature macro: BPSK_DIFF_ENC_EN (differential
//               encoding of the transmitted symbols).
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_modulator #(
   parameter int unsigned SYM_DIV = 8,
   parameter int unsigned PHASE_W = 30
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic [PHASE_W-1:0] carrier,
   bpsk_modulator_if.slave         bus
);

   localparam int unsigned          c_CNT_W    = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
   localparam logic [c_CNT_W-1:0]   c_SYM_LAST = c_CNT_W'(SYM_DIV - 1);
   localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   // Quarter-wave table: round(127*sin(pi*a/128)) for a = 0..64.
   function automatic logic [6:0] f_qsin(input logic [6:0] a);
      case (a)
         7'd0:  f_qsin = 7'd0;   7'd1:  f_qsin = 7'd3;   7'd2:  f_qsin = 7'd6;
         7'd3:  f_qsin = 7'd9;   7'd4:  f_qsin = 7'd12;  7'd5:  f_qsin = 7'd16;
         7'd6:  f_qsin = 7'd19;  7'd7:  f_qsin = 7'd22;  7'd8:  f_qsin = 7'd25;
         7'd9:  f_qsin = 7'd28;  7'd10: f_qsin = 7'd31;  7'd11: f_qsin = 7'd34;
         7'd12: f_qsin = 7'd37;  7'd13: f_qsin = 7'd40;  7'd14: f_qsin = 7'd43;
         7'd15: f_qsin = 7'd46;  7'd16: f_qsin = 7'd49;  7'd17: f_qsin = 7'd51;
         7'd18: f_qsin = 7'd54;  7'd19: f_qsin = 7'd57;  7'd20: f_qsin = 7'd60;
         7'd21: f_qsin = 7'd63;  7'd22: f_qsin = 7'd65;  7'd23: f_qsin = 7'd68;
         7'd24: f_qsin = 7'd71;  7'd25: f_qsin = 7'd73;  7'd26: f_qsin = 7'd76;
         7'd27: f_qsin = 7'd78;  7'd28: f_qsin = 7'd81;  7'd29: f_qsin = 7'd83;
         7'd30: f_qsin = 7'd85;  7'd31: f_qsin = 7'd88;  7'd32: f_qsin = 7'd90;
         7'd33: f_qsin = 7'd92;  7'd34: f_qsin = 7'd94;  7'd35: f_qsin = 7'd96;
         7'd36: f_qsin = 7'd98;  7'd37: f_qsin = 7'd100; 7'd38: f_qsin = 7'd102;
         7'd39: f_qsin = 7'd104; 7'd40: f_qsin = 7'd106; 7'd41: f_qsin = 7'd107;
         7'd42: f_qsin = 7'd109; 7'd43: f_qsin = 7'd111; 7'd44: f_qsin = 7'd112;
         7'd45: f_qsin = 7'd113; 7'd46: f_qsin = 7'd115; 7'd47: f_qsin = 7'd116;
         7'd48: f_qsin = 7'd117; 7'd49: f_qsin = 7'd118; 7'd50: f_qsin = 7'd120;
         7'd51: f_qsin = 7'd121; 7'd52: f_qsin = 7'd122; 7'd53: f_qsin = 7'd122;
         7'd54: f_qsin = 7'd123; 7'd55: f_qsin = 7'd124; 7'd56: f_qsin = 7'd125;
         7'd57: f_qsin = 7'd125; 7'd58: f_qsin = 7'd126; 7'd59: f_qsin = 7'd126;
         7'd60: f_qsin = 7'd126; 7'd61: f_qsin = 7'd127; 7'd62: f_qsin = 7'd127;
         7'd63: f_qsin = 7'd127; 7'd64: f_qsin = 7'd127;
         default: f_qsin = 7'd0;
      endcase
   endfunction

   // Full-wave sine from the quarter table by mirror (odd quadrants) and
   // sign (upper half). Range is symmetric, so -128 never appears.
   function automatic logic signed [7:0] f_sine(input logic [7:0] idx);
      logic [6:0] a;
      logic [6:0] m;
      a = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
      m = f_qsin(a);
      f_sine = idx[7] ? -$signed({1'b0, m}) : $signed({1'b0, m});
   endfunction

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_CNT_W-1:0]  r_sym_cnt;
   logic [c_CNT_W-1:0]  w_cnt_nxt;
   logic                r_rst_done;
   logic                r_sym;
   logic                w_sym_new;
   logic                w_ready;
   logic                w_load;
   logic [PHASE_W-1:0]  r_acc;
   logic signed [7:0]   w_lut;
   logic signed [7:0]   r_s1_smp;
   logic                r_s1_neg;
   logic                r_s1_val;
   logic signed [7:0]   r_dout;
   logic                r_dout_valid;

`ifdef BPSK_DIFF_ENC_EN
   logic                r_diff;

   // Differential symbol: new bit XOR previously transmitted symbol.
   assign w_sym_new = bus.din_bit ^ r_diff;

   // Last transmitted symbol; survives idle gaps, only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_diff <= 1'b0;
      end else if (w_load) begin
         r_diff <= w_sym_new;
      end
   end
`else
   assign w_sym_new = bus.din_bit;
`endif

   // Free-running carrier phase; never cleared except by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else begin
         r_acc <= r_acc + carrier;
      end
   end

   assign w_lut = f_sine(r_acc[PHASE_W-1 -: 8]);

   // FSM state, symbol counter, latched symbol and post-reset ready enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_sym_cnt  <= '0;
         r_sym      <= 1'b0;
         r_rst_done <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_sym_cnt  <= w_cnt_nxt;
         r_rst_done <= 1'b1;
         if (w_load) begin
            r_sym <= w_sym_new;
         end
      end
   end

   // Next state, counter and handshake; a bit is taken only on a ready cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_sym_cnt;
      w_ready     = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready   = r_rst_done;
            w_cnt_nxt = '0;
            if (bus.din_valid && r_rst_done) begin
               w_load      = 1'b1;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (r_sym_cnt == c_SYM_LAST) begin
               w_ready   = 1'b1;
               w_cnt_nxt = '0;
               if (bus.din_valid) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_cnt_nxt = r_sym_cnt + c_CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Two-stage output pipe: LUT sample tagged with sign/enable, then modulate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_smp     <= '0;
         r_s1_neg     <= 1'b0;
         r_s1_val     <= 1'b0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_s1_smp     <= w_lut;
         r_s1_neg     <= r_sym;
         r_s1_val     <= (r_state == S_SEND);
         r_dout_valid <= r_s1_val;
         if (!r_s1_val) begin
            r_dout <= '0;
         end else if (r_s1_neg) begin
            r_dout <= -r_s1_smp;
         end else begin
            r_dout <= r_s1_smp;
         end
      end
   end

   assign bus.din_ready  = w_ready;
   assign bus.dout       = r_dout;
   assign bus.dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_bpsk_modulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpsk_modulator
// Description : Directed self-checking bench for bpsk_modulator (SYM_DIV=8,
//               PHASE_W=30). Cycle n counts rising edges after reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpsk_modulator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [29:0] carrier = 30'd268435456;
   int          n = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic signed [7:0] pat [4] = '{8'sd0, 8'sd127, 8'sd0, -8'sd127};

   bpsk_modulator_if bus_if ();

   bpsk_modulator #(.SYM_DIV(8), .PHASE_W(30)) dut (
      .clk     (clk),
      .rst     (rst),
      .carrier (carrier),
      .bus     (bus_if)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish, n=%0d", n);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic wait_until(input int k);
      while (n < k) tick();
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s @n=%0d: observed %b expected %b", tag, n, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic signed [7:0] obs,
                       input logic signed [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s @n=%0d: observed %0d expected %0d", tag, n, obs, exp);
      end
   endtask

   // Reference sine: round(127*sin(2*pi*idx/256)), symmetric rounding.
   function automatic logic signed [7:0] f_ref(input int idx);
      real v;
      int  t;
      v = 127.0 * $sin(6.283185307179586 * idx / 256.0);
      t = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
      return t[7:0];
   endfunction

   // LUT index of the sample seen at cycle n: it used acc = (n-2)*carrier.
   function automatic int f_idx(input int cyc, input logic [29:0] c);
      longint unsigned a;
      a = (longint'(cyc - 2) * longint'(c)) % 64'd1073741824;
      return int'(a >> 22);
   endfunction

   // Async reset: outputs clear at once, ready rises on the first edge after.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk8("rst_dout", bus_if.dout, 8'sd0);
      chk1("rst_dout_valid", bus_if.dout_valid, 1'b0);
      chk1("rst_ready", bus_if.din_ready, 1'b0);
      bus_if.din_valid = 1'b0;
      bus_if.din_bit   = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk1("rst_ready_hold", bus_if.din_ready, 1'b0);
      rst = 1'b0;
      n = 0;
      tick();
      chk1("ready_after_release", bus_if.din_ready, 1'b1);
   endtask

   initial begin
      logic signed [7:0] e;
      logic              sv;
      bus_if.din_valid = 1'b0;
      bus_if.din_bit   = 1'b0;
      @(posedge clk);
      #1;

      // ---- single bit 0, ignored pulse during SEND, drain to idle ----
      do_reset();
      wait_until(3);
      bus_if.din_valid = 1'b1;
      bus_if.din_bit   = 1'b0;
      tick();
      bus_if.din_valid = 1'b0;
      chk1("t2_ready_send", bus_if.din_ready, 1'b0);
      for (int k = 0; k < 12; k++) begin
         tick();
         if (n == 6) begin
            chk1("t5_ready_busy", bus_if.din_ready, 1'b0);
            bus_if.din_valid = 1'b1;
            bus_if.din_bit   = 1'b1;
         end
         if (n == 7) bus_if.din_valid = 1'b0;
         if (n == 10) chk1("t2_ready_mid", bus_if.din_ready, 1'b0);
         if (n == 11) chk1("t2_ready_last", bus_if.din_ready, 1'b1);
         if (n == 12) chk1("t2_ready_idle", bus_if.din_ready, 1'b1);
         e = (n >= 6 && n <= 13) ? pat[(n - 6) % 4] : 8'sd0;
         chk8("t2_dout", bus_if.dout, e);
         chk1("t2_dout_valid", bus_if.dout_valid, (n >= 6 && n <= 13));
      end

      // ---- reset in the middle of a symbol ----
      bus_if.din_valid = 1'b1;
      bus_if.din_bit   = 1'b0;
      tick();
      bus_if.din_valid = 1'b0;
      tick();
      tick();
      chk1("t1_valid_before_rst", bus_if.dout_valid, 1'b1);
      do_reset();

      // ---- bits 0 then 1 back to back ----
      wait_until(3);
      bus_if.din_valid = 1'b1;
      bus_if.din_bit   = 1'b0;
      tick();
      bus_if.din_bit = 1'b1;
      chk1("t3_ready_n4", bus_if.din_ready, 1'b0);
      while (n < 22) begin
         tick();
         if (n == 12) bus_if.din_valid = 1'b0;
         chk1("t3_ready", bus_if.din_ready, (n == 11) || (n >= 19));
         if (n >= 6 && n <= 13)       e = pat[(n - 6) % 4];
         else if (n >= 14 && n <= 21) e = -pat[(n - 6) % 4];
         else                         e = 8'sd0;
         chk8("t3_dout", bus_if.dout, e);
         chk1("t3_dout_valid", bus_if.dout_valid, (n >= 6 && n <= 21));
      end

      // ---- bits 1,1,0 back to back, idle gap, then 1 ----
      do_reset();
      wait_until(3);
      bus_if.din_valid = 1'b1;
      bus_if.din_bit   = 1'b1;
      while (n < 36) begin
         tick();
         if (n == 12) bus_if.din_bit = 1'b0;
         if (n == 20) bus_if.din_valid = 1'b0;
         if (n == 30) chk1("t4_gap_valid", bus_if.dout_valid, 1'b0);
         if (n == 31) begin
            chk1("t4_gap_ready", bus_if.din_ready, 1'b1);
            bus_if.din_valid = 1'b1;
            bus_if.din_bit   = 1'b1;
         end
         if (n == 32) bus_if.din_valid = 1'b0;
`ifdef BPSK_DIFF_ENC_EN
         if (n == 7)  chk8("t4_sym0", bus_if.dout, -8'sd127);
         if (n == 15) chk8("t4_sym1", bus_if.dout, 8'sd127);
         if (n == 23) chk8("t4_sym2", bus_if.dout, 8'sd127);
         if (n == 35) chk8("t4_sym3", bus_if.dout, -8'sd127);
`else
         if (n == 7)  chk8("t4_sym0", bus_if.dout, -8'sd127);
         if (n == 15) chk8("t4_sym1", bus_if.dout, -8'sd127);
         if (n == 23) chk8("t4_sym2", bus_if.dout, 8'sd127);
         if (n == 35) chk8("t4_sym3", bus_if.dout, -8'sd127);
`endif
      end

      // ---- phase continuity across a 13-cycle idle gap ----
      carrier = 30'd268502564;
      do_reset();
      wait_until(3);
      bus_if.din_valid = 1'b1;
      bus_if.din_bit   = 1'b0;
      tick();
      bus_if.din_valid = 1'b0;
      wait_until(24);
      chk1("t6_ready_gap", bus_if.din_ready, 1'b1);
      bus_if.din_valid = 1'b1;
      tick();
      bus_if.din_valid = 1'b0;
      tick();
      chk1("t6_valid_latency", bus_if.dout_valid, 1'b0);
      while (n < 34) begin
         tick();
         chk8("t6_dout", bus_if.dout, f_ref(f_idx(n, carrier)));
         chk1("t6_dout_valid", bus_if.dout_valid, 1'b1);
      end

      // ---- off-grid tuning word, bit 1: exercises many table entries ----
      carrier = 30'd155189248;
      do_reset();
      wait_until(3);
      bus_if.din_valid = 1'b1;
      bus_if.din_bit   = 1'b1;
      tick();
      bus_if.din_valid = 1'b0;
      while (n < 14) begin
         tick();
         sv = (n >= 6 && n <= 13);
         e  = sv ? -f_ref(f_idx(n, carrier)) : 8'sd0;
         chk8("t7_dout", bus_if.dout, e);
         chk1("t7_dout_valid", bus_if.dout_valid, sv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
